dnn_batch_ctrl: RTL and testbench



---
 rtl/dnn_batch_ctrl_pkg.sv | 27 ++
 rtl/dnn_batch_ctrl_if.sv | 49 ++++
 rtl/dnn_batch_ctrl_argmax.sv | 43 ++++
 rtl/dnn_batch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dnn_batch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_batch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dnn_pkg
// Shared definitions for the batch sequencer that drives the fixed-point
// MNIST inference engine.
//   dnn_ctrl_state_t  : sequencer state encoding
//   DNN_NUM_CLASSES   : number of engine class outputs scanned per image
//   DNN_TIMEOUT_CLASS : class code reported when the watchdog fires
//   DNN_ADDR_WIDTH    : engine memory address width (memory port is untouched)
//   DNN_DATA_WIDTH    : width of the signed engine class scores
// ----------------------------------------------------------------------------
package dnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        WAIT,
        SCAN,
        REPORT
    } dnn_ctrl_state_t;

    localparam int         DNN_NUM_CLASSES   = 10;
    localparam int         DNN_ADDR_WIDTH    = 10;
    localparam int         DNN_DATA_WIDTH    = 2;
    localparam logic [3:0] DNN_TIMEOUT_CLASS = 4'hF;

endpackage

// File: rtl/dnn_batch_ctrl_if.sv
// ----------------------------------------------------------------------------
// dnn_batch_ctrl_if
// Bundles the host command, engine control and result handshake signals of
// the batch sequencer.
//   cmd_valid/cmd_ready/cmd_count : host command (images to classify)
//   abort                         : abandon the batch in flight
//   eng_reset/eng_start/eng_done  : engine control and completion
//   eng_out_idx/eng_out           : class select and selected score
//   img_idx                       : image in flight (memory bank select)
//   res_*                         : one result per image, valid/ready
//   busy                          : sequencer not idle
// Modports: slave = the sequencer, master = host plus engine side.
// ----------------------------------------------------------------------------
interface dnn_batch_ctrl_if #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
);

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [CNT_WIDTH-1:0]         cmd_count;
    logic                         abort;
    logic                         eng_reset;
    logic                         eng_start;
    logic                         eng_done;
    logic [3:0]                   eng_out_idx;
    logic signed [DATA_WIDTH-1:0] eng_out;
    logic [CNT_WIDTH-1:0]         img_idx;
    logic                         res_valid;
    logic                         res_ready;
    logic [3:0]                   res_class;
    logic signed [DATA_WIDTH-1:0] res_score;
    logic [CNT_WIDTH-1:0]         res_img;
    logic                         res_timeout;
    logic                         busy;

    modport slave (
        input  cmd_valid, cmd_count, abort, eng_done, eng_out, res_ready,
        output cmd_ready, eng_reset, eng_start, eng_out_idx, img_idx,
               res_valid, res_class, res_score, res_img, res_timeout, busy
    );

    modport master (
        output cmd_valid, cmd_count, abort, eng_done, eng_out, res_ready,
        input  cmd_ready, eng_reset, eng_start, eng_out_idx, img_idx,
               res_valid, res_class, res_score, res_img, res_timeout, busy
    );

endinterface

// File: rtl/dnn_batch_ctrl_argmax.sv
// ----------------------------------------------------------------------------
// dnn_argmax
// Sequential running maximum over a stream of (index, signed score) samples.
//   clk, rst      : clock, synchronous active-low reset
//   i_clear       : current sample starts a new scan (loaded unconditionally)
//   i_valid       : a sample is present this cycle
//   i_idx/i_score : sample index and signed score
//   o_bestIdx     : index of the best sample so far
//   o_bestScore   : score of the best sample so far
// ----------------------------------------------------------------------------
module dnn_argmax #(
    parameter int DATA_WIDTH = 2,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_valid,
    input  logic [IDX_WIDTH-1:0]         i_idx,
    input  logic signed [DATA_WIDTH-1:0] i_score,
    output logic [IDX_WIDTH-1:0]         o_bestIdx,
    output logic signed [DATA_WIDTH-1:0] o_bestScore
);

    logic [IDX_WIDTH-1:0]         r_bestIdx;
    logic signed [DATA_WIDTH-1:0] r_bestScore;

    // A strictly-greater compare means a tie never displaces the earlier
    // (lower) index, so the first occurrence of the maximum wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bestIdx   <= '0;
            r_bestScore <= '0;
        end else if (i_valid && (i_clear || (i_score > r_bestScore))) begin
            r_bestIdx   <= i_idx;
            r_bestScore <= i_score;
        end
    end

    assign o_bestIdx   = r_bestIdx;
    assign o_bestScore = r_bestScore;

endmodule

// File: rtl/dnn_batch_ctrl.sv
// ----------------------------------------------------------------------------
// dnn_batch_ctrl
// Batch sequencer for the fixed-point MNIST engine. Accepts a command for N
// images and, per image, clears and starts the engine, waits for done under
// a watchdog, scans the class outputs for the argmax and hands one result to
// the host over valid/ready.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-low reset
//   bus  : dnn_batch_ctrl_if.slave (command, engine control, results)
// ----------------------------------------------------------------------------
module dnn_batch_ctrl
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH    = DNN_DATA_WIDTH,
    parameter int NUM_CLASSES   = DNN_NUM_CLASSES,
    parameter int CNT_WIDTH     = 8,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic            clk,
    input  logic            rst,
    dnn_batch_ctrl_if.slave bus
);

    localparam logic [3:0]               LAST_K    = 4'(NUM_CLASSES - 1);
    // The watchdog compares the pre-increment value, so firing at all-ones
    // minus one gives exactly 2**TIMEOUT_WIDTH-1 WAIT cycles.
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH-1:0]     ONE       = CNT_WIDTH'(1);

    dnn_ctrl_state_t              r_state;
    dnn_ctrl_state_t              w_nextState;
    logic [CNT_WIDTH-1:0]         r_remaining;
    logic [CNT_WIDTH-1:0]         r_imgIdx;
    logic [3:0]                   r_k;
    logic [TIMEOUT_WIDTH-1:0]     r_wdog;
    logic                         r_engReset;
    logic                         r_engStart;
    logic [CNT_WIDTH-1:0]         r_resImg;
    logic                         r_resTimeout;

    logic                         w_abortTake;
    logic                         w_accept;
    logic                         w_timeout;
    logic                         w_handshake;
    logic [3:0]                   w_bestIdx;
    logic signed [DATA_WIDTH-1:0] w_bestScore;

    assign w_abortTake = bus.abort && (r_state != IDLE);

    // Next-state logic. Abort overrides every transition, so it is applied
    // last; the event strobes are qualified with it in the register block.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && (bus.cmd_count != '0)) begin
                    w_nextState = CLEAR;
                    w_accept    = 1'b1;
                end
            end
            CLEAR:  w_nextState = START;
            START:  w_nextState = WAIT;
            WAIT: begin
                if (bus.eng_done) begin
                    w_nextState = SCAN;
                end else if (r_wdog == WDOG_LAST) begin
                    w_nextState = REPORT;
                    w_timeout   = 1'b1;
                end
            end
            SCAN: begin
                if (r_k == LAST_K) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                if (bus.res_ready) begin
                    w_handshake = 1'b1;
                    w_nextState = (r_remaining == ONE) ? IDLE : CLEAR;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (w_abortTake) begin
            w_nextState = IDLE;
        end
    end

    // State and datapath registers. The engine pulses are registered from
    // the next state so they line up with CLEAR/START, and an abort produces
    // one eng_reset cycle in the IDLE state that follows it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_imgIdx     <= '0;
            r_k          <= '0;
            r_wdog       <= '0;
            r_engReset   <= 1'b0;
            r_engStart   <= 1'b0;
            r_resImg     <= '0;
            r_resTimeout <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_engReset <= (w_nextState == CLEAR) || w_abortTake;
            r_engStart <= (w_nextState == START);
            if (!w_abortTake) begin
                if (w_accept) begin
                    r_remaining <= bus.cmd_count;
                    r_imgIdx    <= '0;
                end
                if (r_state == CLEAR) begin
                    r_wdog <= '0;
                end else if (r_state == WAIT) begin
                    r_wdog <= r_wdog + 1'b1;
                end
                if ((r_state == WAIT) && (w_nextState == SCAN)) begin
                    r_k          <= '0;
                    r_resTimeout <= 1'b0;
                end else if (r_state == SCAN) begin
                    r_k <= r_k + 4'd1;
                end
                if (w_timeout) begin
                    r_resTimeout <= 1'b1;
                end
                if ((w_nextState == REPORT) && (r_state != REPORT)) begin
                    r_resImg <= r_imgIdx;
                end
                if (w_handshake) begin
                    r_remaining <= r_remaining - ONE;
                    if (r_remaining != ONE) begin
                        r_imgIdx <= r_imgIdx + ONE;
                    end
                end
            end
        end
    end

    dnn_argmax #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (4)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (r_k == 4'd0),
        .i_valid     (r_state == SCAN),
        .i_idx       (r_k),
        .i_score     (bus.eng_out),
        .o_bestIdx   (w_bestIdx),
        .o_bestScore (w_bestScore)
    );

    // The argmax registers only move during SCAN, so the result is stable
    // for the whole of REPORT; a watchdog result masks them.
    assign bus.cmd_ready   = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.eng_reset   = r_engReset;
    assign bus.eng_start   = r_engStart;
    assign bus.eng_out_idx = (r_state == SCAN) ? r_k : 4'd0;
    assign bus.img_idx     = r_imgIdx;
    assign bus.res_valid   = (r_state == REPORT);
    assign bus.res_class   = r_resTimeout ? DNN_TIMEOUT_CLASS : w_bestIdx;
    assign bus.res_score   = r_resTimeout ? '0 : w_bestScore;
    assign bus.res_img     = r_resImg;
    assign bus.res_timeout = r_resTimeout;

endmodule

// File: tb/tb_dnn_batch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dnn_batch_ctrl
// Self-checking bench for dnn_batch_ctrl with a behavioural engine model and
// a result scoreboard. The watchdog is shortened to 6 bits (63 WAIT cycles).
// ----------------------------------------------------------------------------
module tb_dnn_batch_ctrl;

    localparam int TW = 6;

    typedef struct {
        logic [3:0] cls;
        int         score;
        int         img;
        logic       to;
    } result_t;

    logic    clk = 1'b0;
    logic    rst;
    int      numChecks = 0;
    int      numFails  = 0;
    int      cycleCnt  = 0;
    int      stamp     = 0;
    int      startCount = 0;
    int      resetCount = 0;
    int      engDelay  = 0;
    int      engCnt    = 0;
    logic    engRun    = 1'b0;
    int      rotStep   = 0;
    int      scores [10];
    int      scoreInit [10];
    result_t expQ [$];

    dnn_batch_ctrl_if #(.DATA_WIDTH(2), .CNT_WIDTH(8)) bus ();

    dnn_batch_ctrl #(
        .DATA_WIDTH    (2),
        .NUM_CLASSES   (10),
        .CNT_WIDTH     (8),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle stamp plus pulse counters for the engine control outputs.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (bus.eng_start) startCount <= startCount + 1;
        if (bus.eng_reset) resetCount <= resetCount + 1;
    end

    // Engine model: done rises engDelay cycles after the start pulse (0 means
    // never) and is held until the next clear.
    always @(posedge clk) begin
        if (!rst || bus.eng_reset) begin
            engRun <= 1'b0;
            engCnt <= 0;
        end else if (bus.eng_start) begin
            engRun <= 1'b1;
            engCnt <= 1;
        end else if (engRun) begin
            engCnt <= engCnt + 1;
        end
    end

    assign bus.eng_done = engRun && (engDelay != 0) && (engCnt >= engDelay);

    // Score table rotated by image index so each image has its own argmax.
    always_comb begin
        int j;
        j = (int'(bus.eng_out_idx) + rotStep * int'(bus.img_idx)) % 10;
        bus.eng_out = (bus.eng_out_idx < 4'd10) ? 2'(scores[j]) : 2'sb00;
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic loadScores();
        for (int i = 0; i < 10; i++) scores[i] = scoreInit[i];
    endtask

    task automatic pushExpected(input int img);
        result_t r;
        r.img = img;
        if (engDelay == 0) begin
            r.cls = 4'hF; r.score = 0; r.to = 1'b1;
        end else begin
            r.to = 1'b0;
            r.cls = 4'd0;
            r.score = scores[(rotStep * img) % 10];
            for (int k = 1; k < 10; k++) begin
                int v;
                v = scores[(k + rotStep * img) % 10];
                if (v > r.score) begin
                    r.score = v;
                    r.cls = 4'(k);
                end
            end
        end
        expQ.push_back(r);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_cmd_ready"},   32'(bus.cmd_ready),   1);
        checkOutput({pfx, "_busy"},        32'(bus.busy),        0);
        checkOutput({pfx, "_eng_reset"},   32'(bus.eng_reset),   0);
        checkOutput({pfx, "_eng_start"},   32'(bus.eng_start),   0);
        checkOutput({pfx, "_eng_out_idx"}, 32'(bus.eng_out_idx), 0);
        checkOutput({pfx, "_img_idx"},     32'(bus.img_idx),     0);
        checkOutput({pfx, "_res_valid"},   32'(bus.res_valid),   0);
        checkOutput({pfx, "_res_class"},   32'(bus.res_class),   0);
        checkOutput({pfx, "_res_score"},   32'(bus.res_score),   0);
        checkOutput({pfx, "_res_img"},     32'(bus.res_img),     0);
        checkOutput({pfx, "_res_timeout"}, 32'(bus.res_timeout), 0);
    endtask

    task automatic checkFields(input string pfx, input result_t e);
        checkOutput({pfx, "_class"},   32'(bus.res_class),   32'(e.cls));
        checkOutput({pfx, "_score"},   32'(bus.res_score),   e.score);
        checkOutput({pfx, "_img"},     32'(bus.res_img),     e.img);
        checkOutput({pfx, "_timeout"}, 32'(bus.res_timeout), 32'(e.to));
    endtask

    // Issue one command at a negedge and push the expected results.
    task automatic applyStimulus(input int count, input int delay, input int pushCount);
        engDelay = delay;
        for (int i = 0; i < pushCount; i++) pushExpected(i);
        bus.cmd_count = 8'(count);
        bus.cmd_valid = 1'b1;
        stamp = cycleCnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_count = '0;
    endtask

    // Wait for a result, compare it with the scoreboard, optionally stall,
    // then complete the handshake and check what follows it.
    task automatic checkResult(input string tag, input int expLat, input int stall, input bit last);
        result_t e;
        int waited = 0;
        while (!bus.res_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.res_valid) begin
            checkOutput({tag, "_res_valid_wait"}, 0, 1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        e = expQ.pop_front();
        if (expLat >= 0) checkOutput({tag, "_latency"}, cycleCnt - stamp, expLat);
        checkFields(tag, e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({tag, "_stall_valid"}, 32'(bus.res_valid), 1);
            checkFields({tag, "_stall"}, e);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        if (last) begin
            checkOutput({tag, "_busy_after"}, 32'(bus.busy), 0);
            checkOutput({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 1);
        end else begin
            checkOutput({tag, "_busy_after"}, 32'(bus.busy), 1);
            checkOutput({tag, "_b2b_clear"}, 32'(bus.eng_reset), 1);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got 0, expected 1");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int base;
        int waited;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_count = '0;
        bus.abort = 1'b0;
        bus.res_ready = 1'b0;
        scoreInit = '{0, 1, -1, 0, 1, -2, 0, 0, -1, 0};
        loadScores();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single image");
        rotStep = 0;
        applyStimulus(1, 5, 1);
        checkResult("single", 18, 0, 1'b1);

        $display("[TB] batch of 3 with stall");
        rotStep = 3;
        base = startCount;
        applyStimulus(3, 1, 3);
        checkResult("batch0", 14, 0, 1'b0);
        checkResult("batch1", -1, 4, 1'b0);
        checkResult("batch2", -1, 0, 1'b1);
        checkOutput("batch_start_pulses", startCount - base, 3);

        $display("[TB] watchdog timeout");
        rotStep = 0;
        applyStimulus(2, 0, 2);
        checkResult("timeout0", 3 + (2**TW - 1), 0, 1'b0);
        checkResult("timeout1", -1, 0, 1'b1);

        $display("[TB] equal scores and done on the terminal count");
        scoreInit = '{-2, -2, -2, -2, -2, -2, -2, -2, -2, -2};
        loadScores();
        applyStimulus(1, 3, 1);
        checkResult("equal", 16, 0, 1'b1);
        scoreInit = '{0, 1, -1, 0, 1, -2, 0, 0, -1, 0};
        loadScores();
        applyStimulus(1, 2**TW - 1, 1);
        checkResult("done_tc", 3 + (2**TW - 1) + 10, 0, 1'b1);

        $display("[TB] abort ignored in IDLE");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("idle_abort_eng_reset", 32'(bus.eng_reset), 0);
        checkOutput("idle_abort_busy", 32'(bus.busy), 0);

        $display("[TB] abort during SCAN of image 2");
        rotStep = 1;
        applyStimulus(5, 1, 2);
        checkResult("abort0", -1, 0, 1'b0);
        checkResult("abort1", -1, 0, 1'b0);
        checkOutput("abort_img_idx", 32'(bus.img_idx), 2);
        waited = 0;
        while (bus.eng_out_idx != 4'd3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_reached_scan", 32'(bus.eng_out_idx), 3);
        base = resetCount;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_res_valid", 32'(bus.res_valid), 0);
        checkOutput("abort_eng_reset", 32'(bus.eng_reset), 1);
        checkOutput("abort_eng_out_idx", 32'(bus.eng_out_idx), 0);
        @(negedge clk);
        checkOutput("abort_eng_reset_end", 32'(bus.eng_reset), 0);
        checkOutput("abort_reset_pulses", resetCount - base, 1);
        applyStimulus(1, 5, 1);
        checkResult("after_abort", 18, 0, 1'b1);

        $display("[TB] zero-count command");
        base = startCount;
        applyStimulus(0, 1, 0);
        checkOutput("zero_cmd_ready", 32'(bus.cmd_ready), 1);
        checkOutput("zero_busy", 32'(bus.busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("zero_start_pulses", startCount - base, 0);

        $display("[TB] reset during WAIT");
        applyStimulus(1, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("wait_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("wait_rst");
        rst = 1'b1;
        @(negedge clk);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
